// File: rtl/fir_hex_display_if.sv
// fir_hex_display_if: sample bus and display outputs of the FIR hex display stage.
// The master side drives samples; the slave side is the display converter.
interface fir_hex_display_if #(
  parameter int DATA_W = 16
);
  logic signed [DATA_W-1:0] data_in;
  logic                     data_valid;
  logic [6:0]               HEX0;
  logic [6:0]               HEX1;
  logic [6:0]               HEX2;
  logic [6:0]               HEX3;
  logic                     LEDG;
  logic                     busy;

  modport master (
    output data_in,
    output data_valid,
    input  HEX0,
    input  HEX1,
    input  HEX2,
    input  HEX3,
    input  LEDG,
    input  busy
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output HEX0,
    output HEX1,
    output HEX2,
    output HEX3,
    output LEDG,
    output busy
  );
endinterface

// File: rtl/fir_hex_display.sv
// fir_hex_display: converts signed FIR samples to sign + four BCD digits with a
// sequential double-dabble engine and drives four active-low seven-segment
// displays. Samples arriving during a conversion go to a one-deep, newest-wins
// pending buffer.
// Optional build macro: LEADING_ZERO_BLANK_EN -- blank leading zeros on HEX3..HEX1.
module fir_hex_display #(
  parameter int DATA_W = 16
) (
  input logic              CLOCK_50,
  input logic              reset,
  fir_hex_display_if.slave bus
);

  // Wide samples need more than five digits so that overflow detection never
  // loses significant digits off the top of the accumulator.
  localparam int N_DIG = (DATA_W > 16) ? 8 : 5;
  localparam int BCD_W = 4 * N_DIG;
  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [DATA_W-1:0]  r_sample;
  logic [DATA_W-1:0]  r_pend;
  logic               r_pend_full;
  logic               r_sign;
  logic [DATA_W-1:0]  r_mag;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic [6:0]         r_hex0;
  logic [6:0]         r_hex1;
  logic [6:0]         r_hex2;
  logic [6:0]         r_hex3;
  logic               r_ledg;

  logic [DATA_W-1:0]  w_abs;
  logic [BCD_W-1:0]   w_bcd_adj;
  logic               w_ovf;
  logic [6:0]         w_seg0;
  logic [6:0]         w_seg1;
  logic [6:0]         w_seg2;
  logic [6:0]         w_seg3;

  // Active-low segment pattern for one decimal digit (bit 0 = a, bit 6 = g).
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_encode = 7'h40;
      4'd1:    seg_encode = 7'h79;
      4'd2:    seg_encode = 7'h24;
      4'd3:    seg_encode = 7'h30;
      4'd4:    seg_encode = 7'h19;
      4'd5:    seg_encode = 7'h12;
      4'd6:    seg_encode = 7'h02;
      4'd7:    seg_encode = 7'h78;
      4'd8:    seg_encode = 7'h00;
      4'd9:    seg_encode = 7'h10;
      default: seg_encode = SEG_BLANK;
    endcase
  endfunction

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: IDLE -> LOAD -> SHIFT x DATA_W -> UPDATE -> IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.data_valid || r_pend_full) begin
          w_next = ST_LOAD;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_LOAD: w_next = ST_SHIFT;
      ST_SHIFT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_next = ST_UPDATE;
        end else begin
          w_next = ST_SHIFT;
        end
      end
      ST_UPDATE: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Magnitude of the captured sample. The unsigned DATA_W-bit result of the
  // two's-complement negation is exact even for the most negative value.
  always_comb begin
    w_abs = r_sample;
    if (r_sample[DATA_W-1]) begin
      w_abs = ~r_sample + {{(DATA_W-1){1'b0}}, 1'b1};
    end else begin
      w_abs = r_sample;
    end
  end

  // Double-dabble correction: add 3 to every BCD digit that is 5 or more.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < N_DIG; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end else begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4];
      end
    end
  end

  // Display patterns from the finished BCD result, with overflow dashes and
  // optional leading-zero blanking.
  always_comb begin
    w_ovf  = |r_bcd[BCD_W-1:16];
    w_seg0 = seg_encode(r_bcd[3:0]);
    w_seg1 = seg_encode(r_bcd[7:4]);
    w_seg2 = seg_encode(r_bcd[11:8]);
    w_seg3 = seg_encode(r_bcd[15:12]);
    if (w_ovf) begin
      w_seg0 = SEG_DASH;
      w_seg1 = SEG_DASH;
      w_seg2 = SEG_DASH;
      w_seg3 = SEG_DASH;
    end else begin
`ifdef LEADING_ZERO_BLANK_EN
      if (r_bcd[15:12] == 4'd0) begin
        w_seg3 = SEG_BLANK;
        if (r_bcd[11:8] == 4'd0) begin
          w_seg2 = SEG_BLANK;
          if (r_bcd[7:4] == 4'd0) begin
            w_seg1 = SEG_BLANK;
          end else begin
            w_seg1 = seg_encode(r_bcd[7:4]);
          end
        end else begin
          w_seg2 = seg_encode(r_bcd[11:8]);
        end
      end else begin
        w_seg3 = seg_encode(r_bcd[15:12]);
      end
`else
      w_seg3 = seg_encode(r_bcd[15:12]);
`endif
    end
  end

  // Datapath: capture, load, shift steps, display update and pending buffer.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_sample    <= {DATA_W{1'b0}};
      r_pend      <= {DATA_W{1'b0}};
      r_pend_full <= 1'b0;
      r_sign      <= 1'b0;
      r_mag       <= {DATA_W{1'b0}};
      r_bcd       <= {BCD_W{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_hex0      <= SEG_BLANK;
      r_hex1      <= SEG_BLANK;
      r_hex2      <= SEG_BLANK;
      r_hex3      <= SEG_BLANK;
      r_ledg      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // The buffered sample is older, so it is converted first.
          if (r_pend_full) begin
            r_sample    <= r_pend;
            r_pend_full <= 1'b0;
          end else if (bus.data_valid) begin
            r_sample <= bus.data_in;
          end
        end
        ST_LOAD: begin
          r_sign <= r_sample[DATA_W-1];
          r_mag  <= w_abs;
          r_bcd  <= {BCD_W{1'b0}};
          r_cnt  <= CNT_W'(DATA_W);
        end
        ST_SHIFT: begin
          {r_bcd, r_mag} <= {w_bcd_adj, r_mag} << 1;
          r_cnt          <= r_cnt - CNT_W'(1);
        end
        ST_UPDATE: begin
          r_hex0 <= w_seg0;
          r_hex1 <= w_seg1;
          r_hex2 <= w_seg2;
          r_hex3 <= w_seg3;
          r_ledg <= r_sign;
        end
        default: begin
          r_cnt <= {CNT_W{1'b0}};
        end
      endcase
      // Newest-wins buffer: written whenever the sample cannot start right now.
      if (bus.data_valid && ((r_state != ST_IDLE) || r_pend_full)) begin
        r_pend      <= bus.data_in;
        r_pend_full <= 1'b1;
      end
    end
  end

  assign bus.HEX0 = r_hex0;
  assign bus.HEX1 = r_hex1;
  assign bus.HEX2 = r_hex2;
  assign bus.HEX3 = r_hex3;
  assign bus.LEDG = r_ledg;
  assign bus.busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fir_hex_display.sv
// tb_fir_hex_display: directed, table-driven bench for fir_hex_display (DATA_W = 16).
// Honours LEADING_ZERO_BLANK_EN when deciding the expected leading-digit pattern.
module tb_fir_hex_display;
  localparam int DATA_W = 16;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif
  localparam logic [6:0] BL = 7'h7F;
  localparam logic [6:0] DS = 7'h3F;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;

  fir_hex_display_if #(.DATA_W(DATA_W)) bus ();
  fir_hex_display #(.DATA_W(DATA_W)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int total   = 0;
  int bad     = 0;
  int changes = 0;

  logic [28:0] w_disp;
  logic [28:0] last_disp = 29'd0;
  assign w_disp = {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0, bus.LEDG};

  // Count every visible change of the display between clock edges.
  always @(negedge CLOCK_50) begin
    if (w_disp !== last_disp) changes <= changes + 1;
    last_disp <= w_disp;
  end

  typedef struct {
    string                    name;
    logic signed [DATA_W-1:0] din;
    logic [28:0]              exp_disp;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic signed [DATA_W-1:0] din);
    bus.data_in    = din;
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
  endtask

  // Counts busy cycles after the current point, bounded at 40.
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    int c0;
    int busy_seen;

    vecs[0] = '{"v1234",  16'sd1234,   {7'h79, 7'h24, 7'h30, 7'h19, 1'b0}};
    vecs[1] = '{"vm56",   -16'sd56,    {LZ, LZ, 7'h12, 7'h02, 1'b1}};
    vecs[2] = '{"v10000", 16'sd10000,  {DS, DS, DS, DS, 1'b0}};
    vecs[3] = '{"vmin",   -16'sd32768, {DS, DS, DS, DS, 1'b1}};
    vecs[4] = '{"v0",     16'sd0,      {LZ, LZ, LZ, 7'h40, 1'b0}};
    vecs[5] = '{"v9999",  16'sd9999,   {7'h10, 7'h10, 7'h10, 7'h10, 1'b0}};
    vecs[6] = '{"vm1",    -16'sd1,     {LZ, LZ, LZ, 7'h79, 1'b1}};
    vecs[7] = '{"v305",   16'sd305,    {LZ, 7'h30, 7'h40, 7'h12, 1'b0}};
    vecs[8] = '{"vm9999", -16'sd9999,  {7'h10, 7'h10, 7'h10, 7'h10, 1'b1}};
    vecs[9] = '{"vmax",   16'sd32767,  {DS, DS, DS, DS, 1'b0}};

    bus.data_in    = '0;
    bus.data_valid = 1'b0;
    reset          = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("reset_disp", 32'(w_disp), 32'({BL, BL, BL, BL, 1'b0}));
    check("reset_busy", 32'(bus.busy), 32'd0);
    tick();
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Table: one sample each, 18 busy cycles, result visible when busy drops.
    for (int i = 0; i < 10; i++) begin
      pulse(vecs[i].din);
      wait_idle(n);
      check({vecs[i].name, "_busy"}, 32'(n), 32'd18);
      check({vecs[i].name, "_disp"}, 32'(w_disp), 32'(vecs[i].exp_disp));
      repeat (2) tick();
    end

    // Newest-wins pending buffer: 7 shown, then 33; 11 and 22 dropped.
    c0 = changes;
    pulse(16'sd7);
    repeat (3) tick();
    pulse(16'sd11);
    repeat (3) tick();
    pulse(16'sd22);
    repeat (3) tick();
    pulse(16'sd33);
    wait_idle(n);
    check("pend_first_disp", 32'(w_disp), 32'({LZ, LZ, LZ, 7'h78, 1'b0}));
    tick();
    check("pend_restart", 32'(bus.busy), 32'd1);
    wait_idle(n);
    check("pend_second_busy", 32'(n), 32'd18);
    check("pend_second_disp", 32'(w_disp), 32'({LZ, LZ, 7'h30, 7'h30, 1'b0}));
    busy_seen = 0;
    repeat (25) begin
      tick();
      if (bus.busy === 1'b1) busy_seen++;
    end
    check("pend_no_third", 32'(busy_seen), 32'd0);
    check("pend_changes", 32'(changes - c0), 32'd2);

    // Reset on the 5th SHIFT cycle of 9999 with a sample pending.
    pulse(16'sd9999);
    tick();
    pulse(16'sd4321);
    repeat (3) tick();
    check("rst_mid_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
    check("rst_mid_disp", 32'(w_disp), 32'({BL, BL, BL, BL, 1'b0}));
    check("rst_mid_busy0", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    busy_seen = 0;
    repeat (30) begin
      tick();
      if (bus.busy === 1'b1) busy_seen++;
    end
    check("rst_no_resume", 32'(busy_seen), 32'd0);
    check("rst_hold_disp", 32'(w_disp), 32'({BL, BL, BL, BL, 1'b0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fir_hex_display.md
# fir_hex_display

Downstream display stage for the FIR filter top level. It captures each signed filter output sample and converts its magnitude to four BCD digits with a sequential double-dabble engine. It drives the four active-low seven-segment displays HEX3..HEX0 and a sign LED on LEDG. Samples that arrive while a conversion is running are held in a one-deep buffer in which the newest sample wins.

## Interface
- DATA_W, default 16: width of the two's-complement input sample; legal range 8..24.
- CLOCK_50  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  DATA_W  signed FIR output sample.
- data_valid  in  1  single-cycle strobe; data_in is valid in the same cycle.
- HEX0..HEX3  out  7 each  seven-segment outputs, active low.
  - Bit 0 is segment a and bit 6 is segment g.
  - HEX0 is the ones digit; HEX3 is the thousands digit.
- LEDG  out  1  sign of the currently displayed value (1 = negative).
- busy  out  1  high while a conversion is in progress.

## Operation
- FSM states: IDLE, LOAD, SHIFT, UPDATE.
- IDLE:
  - On data_valid, or when the pending buffer is full, capture the sample. The buffer has priority and is cleared when used.
  - Go to LOAD.
- LOAD:
  - sign = sample MSB.
  - mag = |sample|, computed at DATA_W+1 bits so that the most negative value is exact.
  - Clear the 5-digit BCD accumulator and load bit counter = DATA_W.
  - Go to SHIFT.
- SHIFT: one double-dabble step per cycle, DATA_W cycles in total.
  - Add 3 to every BCD digit that is ≥5.
  - Shift {BCD, mag} left by 1.
  - Decrement the counter; at 0 go to UPDATE.
- UPDATE:
  - Register HEX0..HEX3 and LEDG from the BCD result.
  - If the result is > 9999 (fifth digit nonzero), all four digits show a dash, 7'b0111111. LEDG still reflects the sign.
  - Go to IDLE.
- Digit encoding:
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
  - Blank = 0x7F.
- Pending buffer:
  - data_valid in any non-IDLE state writes data_in into the buffer and sets its full flag. A later write overwrites the earlier one.
  - data_valid in IDLE while the buffer is full: the buffer is consumed and the new sample is stored into the buffer.
- Displayed outputs change only in UPDATE. They hold their values between conversions.
- busy = (state != IDLE).

## Timing
- Reset values:
  - HEX0..HEX3 = 0x7F.
  - LEDG = 0, busy = 0.
  - FSM in IDLE; pending flag cleared; BCD accumulator and counter cleared.
- Reset asserted mid-conversion aborts the conversion and drops any pending sample. Outputs return to their reset values on the next edge.
- Latency: data_valid in IDLE at edge N gives LOAD at N+1, SHIFT at N+2..N+1+DATA_W, and UPDATE at N+2+DATA_W.
- New HEX and LEDG values are visible after edge N+3+DATA_W, which is 19 cycles for DATA_W = 16.
- busy is high from after edge N+1 through the UPDATE cycle.
- Back-to-back throughput: one sample per DATA_W+3 cycles. A pending sample starts on the first IDLE cycle after UPDATE.
- Sample values:
  - 0 → "0000" (or "   0" when blanking is on).
  - Magnitudes 1..9999 are exact.
  - -(2^(DATA_W-1)) gives dashes when its magnitude is > 9999.

## Configuration
- LEADING_ZERO_BLANK_EN:
  - Defined: in UPDATE, leading zero digits in HEX3, HEX2 and HEX1 are driven 0x7F. HEX0 always shows a digit. The dash overflow pattern is unaffected.
  - Undefined: all four digits are always shown, including leading zeros.

## Test plan
- Reset, then data_in=1234 with one data_valid:
  - 19 cycles later HEX3..HEX0 = 0x79, 0x24, 0x30, 0x19, LEDG=0.
  - busy is high for exactly 18 cycles.
- data_in=-56:
  - LEDG=1, HEX1=0x12, HEX0=0x02.
  - HEX3/HEX2 = 0x7F with LEADING_ZERO_BLANK_EN, 0x40 without it.
- data_in=10000, then data_in=-32768: both show all HEX = 0x3F; LEDG = 0, then LEDG = 1.
- Accept 7. Pulse data_valid with 11, 22 and 33 during busy:
  - Display shows 7, then 33. Values 11 and 22 are never displayed.
  - The second conversion starts the first IDLE cycle after UPDATE.
- Assert reset on the 5th SHIFT cycle of 9999 while a sample is pending:
  - Outputs go to 0x7F / LEDG 0 / busy 0.
  - No conversion resumes after reset is released.
- data_in=0:
  - HEX0=0x40; HEX3..HEX1 blank or 0x40 according to the macro; LEDG=0.
